// File: rtl/tank_pkg.sv
// Shared types and helpers for the keypad front end of the tank game:
// key codes, frame classes, debounce states and row-vector helpers.
package tank_pkg;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_SINGLE = 2'd1,
    CLS_MULTI  = 2'd2
  } frame_cls_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEB  = 2'd1,
    ST_HELD = 2'd2,
    ST_REL  = 2'd3
  } deb_state_e;

  localparam logic [3:0] KEY_BTN1_DEF = 4'd1;
  localparam logic [3:0] KEY_BTN0_DEF = 4'd3;
  localparam logic [3:0] KEY_FIRE_DEF = 4'd5;

  // Number of set bits, saturated at 2 (only none/one/many matters).
  function automatic logic [1:0] row_count(input logic [3:0] rows);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, rows[i]};
    end
    return (n > 3'd1) ? 2'd2 : n[1:0];
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rows[i]) begin
        idx = 2'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce: turns one classified frame per scan into accepted
// press / release decisions for a single key code.
module keypad_debounce
  import tank_pkg::*;
#(
  parameter int DEB_FRAMES = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       frame_done_i,
  input  logic [1:0] cls_i,
  input  logic [3:0] code_i,
  output logic [3:0] code_o,
  output logic       valid_o,
  output logic       held_o,
  output logic [3:0] code_nx_o,
  output logic       held_nx_o
);

  localparam int CW = (DEB_FRAMES > 1) ? $clog2(DEB_FRAMES + 1) : 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_FRAMES - 1);

  deb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;
  logic          accept_s;
  logic          single_s;
  logic          hit_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cand_q  <= 4'd0;
      code_q  <= 4'd0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  // Counters only ever step while below the threshold, so they cannot wrap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    accept_s = 1'b0;
    single_s = (cls_i == CLS_SINGLE);
    hit_s    = single_s && (code_i == cand_q);
    if (frame_done_i) begin
      case (state_q)
        ST_IDLE: begin
          if (single_s) begin
            cand_d = code_i;
            cnt_d  = CNT_ONE;
            if (DEB_FRAMES == 1) begin
              state_d  = ST_HELD;
              accept_s = 1'b1;
            end else begin
              state_d = ST_DEB;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DEB: begin
          if (hit_s) begin
            if (cnt_q >= CNT_LAST) begin
              state_d  = ST_HELD;
              accept_s = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else if (single_s) begin
            cand_d = code_i;
            cnt_d  = CNT_ONE;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_HELD: begin
          if (hit_s) begin
            state_d = ST_HELD;
          end else if (DEB_FRAMES == 1) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = ST_REL;
            cnt_d   = CNT_ONE;
          end
        end
        ST_REL: begin
          if (hit_s) begin
            state_d = ST_HELD;
          end else if (cnt_q >= CNT_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_comb begin
    held_d  = (state_d == ST_HELD) || (state_d == ST_REL);
    valid_d = accept_s;
    if (accept_s) begin
      code_d = cand_d;
    end else begin
      code_d = code_q;
    end
  end

  assign code_o    = code_q;
  assign valid_o   = valid_q;
  assign held_o    = held_q;
  assign code_nx_o = code_d;
  assign held_nx_o = held_d;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 active-low key matrix scanner: column strobing, row synchronisation,
// frame classification, debounce and mapping onto the tank control inputs.
module keypad_scan_ctrl
  import tank_pkg::*;
#(
  parameter int         SCAN_DIV   = 1000,
  parameter int         DEB_FRAMES = 3,
  parameter logic [3:0] KEY_BTN1   = KEY_BTN1_DEF,
  parameter logic [3:0] KEY_BTN0   = KEY_BTN0_DEF,
  parameter logic [3:0] KEY_FIRE   = KEY_FIRE_DEF
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [3:0] iKEY_ROW,
  output logic [3:0] oKEY_COL,
  output logic [3:0] oKEY_CODE,
  output logic       oKEY_VALID,
  output logic       oKEY_HELD,
  output logic [1:0] oBUTTON,
  output logic       oFIRE_N
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    col_n_q, col_n_d;
  logic [3:0]    sync1_q, sync2_q;
  logic [1:0]    acc_cnt_q, acc_cnt_d;
  logic [3:0]    acc_code_q, acc_code_d;
  logic [1:0]    button_q, button_d;
  logic          fire_n_q, fire_n_d;

  logic          sample_s;
  logic          frame_done_s;
  logic [3:0]    pressed_s;
  logic [2:0]    sum_s;
  logic [1:0]    tot_cnt_s;
  logic [3:0]    frame_code_s;
  logic [1:0]    cls_s;
  logic [3:0]    code_nx_s;
  logic          held_nx_s;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      dwell_q    <= '0;
      col_q      <= 2'd0;
      col_n_q    <= 4'b1111;
      sync1_q    <= 4'b1111;
      sync2_q    <= 4'b1111;
      acc_cnt_q  <= 2'd0;
      acc_code_q <= 4'd0;
      button_q   <= 2'b00;
      fire_n_q   <= 1'b1;
    end else begin
      dwell_q    <= dwell_d;
      col_q      <= col_d;
      col_n_q    <= col_n_d;
      sync1_q    <= iKEY_ROW;
      sync2_q    <= sync1_q;
      acc_cnt_q  <= acc_cnt_d;
      acc_code_q <= acc_code_d;
      button_q   <= button_d;
      fire_n_q   <= fire_n_d;
    end
  end

  // Accumulated frame keeps only a saturated bit count and the code of the
  // first pressed bit; a code is only meaningful when the count ends at one.
  always_comb begin
    sample_s     = (dwell_q == DWELL_LAST);
    frame_done_s = sample_s && (col_q == 2'd3);
    dwell_d      = sample_s ? '0 : (dwell_q + DW'(1));
    col_d        = sample_s ? (col_q + 2'd1) : col_q;
    col_n_d      = ~(4'b0001 << col_q);
    pressed_s    = ~sync2_q;
    sum_s        = {1'b0, acc_cnt_q} + {1'b0, row_count(pressed_s)};
    tot_cnt_s    = (sum_s > 3'd1) ? 2'd2 : sum_s[1:0];
    if (acc_cnt_q == 2'd1) begin
      frame_code_s = acc_code_q;
    end else begin
      frame_code_s = {row_index(pressed_s), col_q};
    end
    case (tot_cnt_s)
      2'd0:    cls_s = CLS_NONE;
      2'd1:    cls_s = CLS_SINGLE;
      default: cls_s = CLS_MULTI;
    endcase
    if (frame_done_s) begin
      acc_cnt_d  = 2'd0;
      acc_code_d = 4'd0;
    end else if (sample_s) begin
      acc_cnt_d  = tot_cnt_s;
      acc_code_d = frame_code_s;
    end else begin
      acc_cnt_d  = acc_cnt_q;
      acc_code_d = acc_code_q;
    end
  end

  keypad_debounce #(
    .DEB_FRAMES(DEB_FRAMES)
  ) u_debounce (
    .clk_i       (iCLK),
    .rst_i       (iRST),
    .frame_done_i(frame_done_s),
    .cls_i       (cls_s),
    .code_i      (frame_code_s),
    .code_o      (oKEY_CODE),
    .valid_o     (oKEY_VALID),
    .held_o      (oKEY_HELD),
    .code_nx_o   (code_nx_s),
    .held_nx_o   (held_nx_s)
  );

  // Game mapping uses the debouncer's next values so it moves with oKEY_HELD.
  always_comb begin
    button_d = {held_nx_s && (code_nx_s == KEY_BTN1),
                held_nx_s && (code_nx_s == KEY_BTN0)};
    fire_n_d = ~(held_nx_s && (code_nx_s == KEY_FIRE));
  end

  assign oKEY_COL = col_n_q;
  assign oBUTTON  = button_q;
  assign oFIRE_N  = fire_n_q;

endmodule
